// File: rtl/fila_pkg.sv
// rtl/fila_pkg.sv - shared states and constants for the fila drain transmitter
package fila_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_POP,
    ST_SETTLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam int   DATA_BITS     = 8;
  // Wide enough for STOP_BITS*BIT_CYCLES and any practical gap length.
  localparam int   TIMER_W       = 16;

endpackage

// File: rtl/fila_bit_timer.sv
// rtl/fila_bit_timer.sv - loadable down-counter; tick marks the last cycle of a timed interval
module fila_bit_timer
  import fila_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  // Restart loads the full interval, so a state entered with load N lasts N cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == W'(1));

endmodule

// File: rtl/fila_drain_tx.sv
// rtl/fila_drain_tx.sv - pops the fila head element and sends it as an async serial frame
module fila_drain_tx
  import fila_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       enable_in,
  input  logic [7:0] data_in,
  input  logic [7:0] len_in,
  output logic       dequeue_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic [7:0] sent_count_out
);

  localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(BIT_CYCLES);
  localparam logic [TIMER_W-1:0] STOP_LOAD = TIMER_W'(STOP_BITS * BIT_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES);

  tx_state_t          state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_q, bit_d;
  logic               par_q, par_d;
  logic [7:0]         sent_q, sent_d;
  logic               tx_q, tx_d;
  logic               deq_q, deq_d;
  logic               busy_q, busy_d;
  logic               restart;
  logic [TIMER_W-1:0] load_val;
  logic               tick;

  fila_bit_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk_10KHz),
    .rst_n    (reset),
    .restart  (restart),
    .load_val (load_val),
    .tick     (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    par_d    = par_q;
    sent_d   = sent_q;
    restart  = 1'b0;
    load_val = BIT_LOAD;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_in && (len_in != 8'd0)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d = data_in;
        par_d   = ^data_in;
        state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_START;
        restart = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          restart = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          restart = 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              state_d  = ST_STOP;
              load_val = STOP_LOAD;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d  = ST_STOP;
          restart  = 1'b1;
          load_val = STOP_LOAD;
        end
      end
      ST_STOP: begin
        if (tick) begin
          sent_d = sent_q + 8'd1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_GAP;
            restart  = 1'b1;
            load_val = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line lines up with state_q.
    unique case (state_d)
      ST_START:  tx_d = START_LEVEL;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = TX_IDLE_LEVEL;
    endcase
    deq_d  = (state_d == ST_POP);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
      par_q   <= 1'b0;
      sent_q  <= 8'd0;
      tx_q    <= TX_IDLE_LEVEL;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      sent_q  <= sent_d;
      tx_q    <= tx_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_out         = tx_q;
  assign dequeue_out    = deq_q;
  assign busy_out       = busy_q;
  assign sent_count_out = sent_q;

endmodule

// File: tb/tb_fila_drain_tx.sv
// tb/tb_fila_drain_tx.sv - self-checking bench for fila_drain_tx
module tb_fila_drain_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_en, a_deq, a_tx, a_busy;
  logic [7:0] a_data, a_len, a_sent;
  logic       b_en, b_deq, b_tx, b_busy;
  logic [7:0] b_data, b_len, b_sent;

  fila_drain_tx #(.BIT_CYCLES(1), .PARITY_EN(0), .STOP_BITS(1), .GAP_CYCLES(2)) u_a (
    .clk_10KHz(clk), .reset(rst_n), .enable_in(a_en), .data_in(a_data), .len_in(a_len),
    .dequeue_out(a_deq), .tx_out(a_tx), .busy_out(a_busy), .sent_count_out(a_sent)
  );

  fila_drain_tx #(.BIT_CYCLES(3), .PARITY_EN(1), .STOP_BITS(2), .GAP_CYCLES(2)) u_b (
    .clk_10KHz(clk), .reset(rst_n), .enable_in(b_en), .data_in(b_data), .len_in(b_len),
    .dequeue_out(b_deq), .tx_out(b_tx), .busy_out(b_busy), .sent_count_out(b_sent)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  int         n_run = 0;
  int         n_fail = 0;
  logic [7:0] fq_mem [0:15];
  int         fq_head, fq_len;
  int         deq_cnt, rx_cnt, idle_run, cyc;
  bit         have_prev;
  logic [9:0] rx_raw;
  logic [9:0] rx_frames [$];
  int         gaps [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One cycle of DUT A: fila model, pop counting and a 10-sample frame decoder.
  task automatic tick_a();
    @(negedge clk);
    cyc++;
    if (a_deq === 1'b1) begin
      deq_cnt++;
      if (fq_len > 0) begin
        fq_head++;
        fq_len--;
      end
    end
    if (rx_cnt == 0) begin
      if (a_tx === 1'b0) begin
        if (have_prev) gaps.push_back(idle_run);
        idle_run = 0;
        rx_raw = '0;
        rx_cnt = 1;
      end else begin
        idle_run++;
      end
    end else begin
      rx_raw[rx_cnt] = a_tx;
      if (rx_cnt == 9) begin
        rx_frames.push_back(rx_raw);
        rx_cnt = 0;
        have_prev = 1'b1;
        idle_run = 0;
      end else begin
        rx_cnt++;
      end
    end
    a_len  = 8'(fq_len);
    a_data = fq_mem[fq_head[3:0]];
  endtask

  vec_t       vecs [6];
  logic       samp [0:79];
  logic       busyv [0:79];
  logic [7:0] sentv [0:79];
  logic [11:0] fb;
  int         exp_sent, s, nf0, d0, lb, ls, b_deq_n;
  bit         seen_busy, seen_deq, seen_low;

  initial begin
    vecs[0] = '{8'h11, {1'b1, 8'h11, 1'b0}};
    vecs[1] = '{8'h00, {1'b1, 8'h00, 1'b0}};
    vecs[2] = '{8'hFF, {1'b1, 8'hFF, 1'b0}};
    vecs[3] = '{8'hA5, {1'b1, 8'hA5, 1'b0}};
    vecs[4] = '{8'h80, {1'b1, 8'h80, 1'b0}};
    vecs[5] = '{8'h01, {1'b1, 8'h01, 1'b0}};
    for (int i = 0; i < 16; i++) fq_mem[i] = 8'h3C;
    fq_head = 0; fq_len = 0; deq_cnt = 0; rx_cnt = 0; idle_run = 0; cyc = 0; have_prev = 1'b0;

    // Reset and empty queue
    rst_n = 1'b0;
    a_en = 1'b1; a_len = 8'd0; a_data = 8'h00;
    b_en = 1'b1; b_len = 8'd0; b_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_deq", 32'(a_deq), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_sent", 32'(a_sent), 32'd0);
    check("rst_b_tx", 32'(b_tx), 32'd1);
    rst_n = 1'b1;
    seen_busy = 0; seen_deq = 0; seen_low = 0;
    repeat (20) begin
      tick_a();
      if (a_busy) seen_busy = 1;
      if (a_deq) seen_deq = 1;
      if (!a_tx) seen_low = 1;
    end
    check("empty_busy", 32'(seen_busy), 32'd0);
    check("empty_deq", 32'(seen_deq), 32'd0);
    check("empty_tx_low", 32'(seen_low), 32'd0);
    check("empty_sent", 32'(a_sent), 32'd0);

    // Parity, two stop bits, three cycles per bit on DUT B
    b_data = 8'h07; b_len = 8'd1; b_deq_n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      samp[c] = b_tx; busyv[c] = b_busy; sentv[c] = b_sent;
      if (b_deq) begin
        b_deq_n++;
        b_len = 8'd0;
      end
    end
    s = -1;
    for (int c = 0; c < 80; c++) if (s < 0 && samp[c] === 1'b0) s = c;
    check("b_start_found", 32'(s >= 0 && s <= 40), 32'd1);
    if (s >= 0 && s <= 40) begin
      fb = {2'b11, 1'b1, 8'h07, 1'b0};
      for (int i = 0; i < 36; i++) check($sformatf("b_frame_bit%0d", i), 32'(samp[s + i]), 32'(fb[i / 3]));
      check("b_gap0", 32'(samp[s + 36]), 32'd1);
      check("b_gap1", 32'(samp[s + 37]), 32'd1);
      check("b_sent_before", 32'(sentv[s + 35]), 32'd0);
      check("b_sent_after", 32'(sentv[s + 36]), 32'd1);
      check("b_busy_gap", 32'(busyv[s + 37]), 32'd1);
      check("b_busy_idle", 32'(busyv[s + 38]), 32'd0);
      check("b_latency", 32'(busyv[s - 3]), 32'd1);
      check("b_pre_load", 32'(busyv[s - 4]), 32'd0);
    end
    check("b_pops", 32'(b_deq_n), 32'd1);

    // Single-frame vectors on DUT A
    exp_sent = 0;
    for (int v = 0; v < 6; v++) begin
      fq_mem[0] = vecs[v].data; fq_head = 0; fq_len = 1;
      nf0 = rx_frames.size(); d0 = deq_cnt; lb = -1; ls = -1;
      for (int k = 0; k < 60 && rx_frames.size() == nf0; k++) begin
        tick_a();
        if (a_busy && lb < 0) lb = cyc;
        if (!a_tx && ls < 0) ls = cyc;
      end
      repeat (12) tick_a();
      exp_sent++;
      check("vec_frame_seen", 32'(rx_frames.size() - nf0), 32'd1);
      if (rx_frames.size() > nf0) check($sformatf("vec_frame_%02h", vecs[v].data), 32'(rx_frames[nf0]), 32'(vecs[v].frame));
      check("vec_latency", 32'(ls - lb), 32'd3);
      check("vec_pops", 32'(deq_cnt - d0), 32'd1);
      check("vec_sent", 32'(a_sent), 32'(exp_sent));
      check("vec_idle", 32'(a_busy), 32'd0);
    end

    // Nine queued elements drained back to back
    for (int i = 0; i < 9; i++) fq_mem[i] = 8'((i + 1) * 17);
    fq_head = 0; fq_len = 9; gaps.delete(); have_prev = 1'b0; idle_run = 0;
    nf0 = rx_frames.size(); d0 = deq_cnt;
    for (int k = 0; k < 400 && rx_frames.size() < nf0 + 9; k++) tick_a();
    repeat (12) tick_a();
    exp_sent += 9;
    check("q9_frames", 32'(rx_frames.size() - nf0), 32'd9);
    for (int i = 0; i < 9 && nf0 + i < rx_frames.size(); i++)
      check($sformatf("q9_frame%0d", i), 32'(rx_frames[nf0 + i]), 32'({1'b1, 8'((i + 1) * 17), 1'b0}));
    check("q9_gap_count", 32'(gaps.size()), 32'd8);
    foreach (gaps[g]) check($sformatf("q9_gap%0d", g), 32'(gaps[g]), 32'd6);
    check("q9_pops", 32'(deq_cnt - d0), 32'd9);
    check("q9_sent", 32'(a_sent), 32'(exp_sent));
    check("q9_len", 32'(fq_len), 32'd0);

    // Enable gating, and dropping enable mid-frame
    for (int i = 0; i < 5; i++) fq_mem[i] = 8'(8'h21 + i);
    fq_head = 0; fq_len = 5; a_en = 1'b0;
    d0 = deq_cnt; seen_busy = 0;
    repeat (30) begin
      tick_a();
      if (a_busy) seen_busy = 1;
    end
    check("dis_pops", 32'(deq_cnt - d0), 32'd0);
    check("dis_busy", 32'(seen_busy), 32'd0);
    a_en = 1'b1; nf0 = rx_frames.size();
    for (int k = 0; k < 40 && rx_cnt != 4; k++) tick_a();
    check("en_in_data", 32'(rx_cnt), 32'd4);
    a_en = 1'b0;
    repeat (40) tick_a();
    exp_sent++;
    check("en_pops", 32'(deq_cnt - d0), 32'd1);
    check("en_frames", 32'(rx_frames.size() - nf0), 32'd1);
    if (rx_frames.size() > nf0) check("en_frame", 32'(rx_frames[nf0]), 32'({1'b1, 8'h21, 1'b0}));
    check("en_len_left", 32'(fq_len), 32'd4);
    check("en_sent", 32'(a_sent), 32'(exp_sent));
    check("en_idle", 32'(a_busy), 32'd0);

    // Asynchronous reset in the middle of a data byte
    fq_mem[0] = 8'hA5; fq_head = 0; fq_len = 1; a_en = 1'b1;
    for (int k = 0; k < 40 && rx_cnt != 3; k++) tick_a();
    check("rst_in_data", 32'(rx_cnt), 32'd3);
    rst_n = 1'b0; fq_len = 0; a_len = 8'd0;
    #1;
    check("arst_tx", 32'(a_tx), 32'd1);
    check("arst_deq", 32'(a_deq), 32'd0);
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_sent", 32'(a_sent), 32'd0);
    rx_cnt = 0; have_prev = 1'b0;
    repeat (3) tick_a();
    rst_n = 1'b1;
    d0 = deq_cnt; nf0 = rx_frames.size(); seen_busy = 0; seen_low = 0;
    repeat (20) begin
      tick_a();
      if (a_busy) seen_busy = 1;
      if (!a_tx) seen_low = 1;
    end
    check("post_rst_pops", 32'(deq_cnt - d0), 32'd0);
    check("post_rst_busy", 32'(seen_busy), 32'd0);
    check("post_rst_tx_low", 32'(seen_low), 32'd0);
    check("post_rst_sent", 32'(a_sent), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fila_drain_tx.md
Name: fila_drain_tx

Overview:
- Downstream consumer of the `fila` 8-bit queue.
- Watches the queue length, pops the head element, and transmits it as an asynchronous serial frame on a single line.
- Runs on the same 10 kHz system clock as the queue.
- Output feeds the board's serial/LED debug line.

Parameters:
BIT_CYCLES, 1, clock cycles per serial bit (1 gives 10 kbaud at 10 kHz); legal range 1..255
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits
STOP_BITS, 1, number of stop bits (1 or 2)
GAP_CYCLES, 2, idle-high cycles forced between frames; 0 is legal

Ports:
clk_10KHz  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable_in  input  1  1 = allowed to start new frames
data_in  input  8  head-of-queue value (fila data_out)
len_in  input  8  current queue length (fila len_out)
dequeue_out  output  1  one-cycle pop pulse to fila dequeue_in
tx_out  output  1  serial line, idle high
busy_out  output  1  high from LOAD through GAP inclusive
sent_count_out  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx_out=1, dequeue_out=0, busy_out=0, sent_count_out=0.
  - Shift register, bit counter and cycle counter all 0.
- State machine: IDLE, LOAD, POP, SETTLE, START, DATA, PARITY, STOP, GAP.
- IDLE -> LOAD when enable_in=1 and len_in!=0. Otherwise stay in IDLE.
- LOAD (1 cycle): capture data_in into the shift register; compute parity as the XOR of the 8 bits.
- POP (1 cycle): dequeue_out=1. This is the only state in which dequeue_out is high.
- SETTLE (1 cycle): dequeue_out=0, giving the queue time to update len/data. Then -> START.
- START: tx_out=0 for BIT_CYCLES cycles. Then -> DATA.
- DATA:
  - tx_out = shift register bit 0; 8 bits, LSB first, each held BIT_CYCLES cycles.
  - Shift right after each bit.
  - After bit 7 -> PARITY if PARITY_EN=1, else -> STOP.
- PARITY: tx_out = even-parity bit for BIT_CYCLES cycles. Then -> STOP.
- STOP:
  - tx_out=1 for STOP_BITS*BIT_CYCLES cycles.
  - On exit, sent_count_out increments by 1 (8-bit wrap).
  - Then -> GAP, or -> IDLE if GAP_CYCLES=0.
- GAP: tx_out=1 for GAP_CYCLES cycles. Then -> IDLE.
- Latency: LOAD to the first start-bit cycle is 3 cycles (LOAD, POP, SETTLE).
- Frame length in cycles: (1 + 8 + PARITY_EN + STOP_BITS)*BIT_CYCLES.
- tx_out is registered and glitch-free; it changes only on clock edges.
- enable_in is sampled only in IDLE. Dropping it mid-frame does not abort the frame.
- Empty queue (len_in=0): stay in IDLE, never pulse dequeue_out.
- len_in=1: after the frame completes and len reaches 0, return to IDLE and stay there.
- Back-to-back frames: len_in is re-evaluated on the IDLE cycle following GAP. No pop is issued without a fresh IDLE check.
- Queue full (len_in=255) needs no special handling: drained one element per frame.
- data_in is ignored outside LOAD. Changes to it mid-frame do not affect the frame in progress.
- Async reset mid-frame: tx_out returns high immediately; the partial frame is lost. An element already popped is not recovered.

Decomposition:
- Package fila_pkg:
  - state enum tx_state_t;
  - constants TX_IDLE_LEVEL=1'b1, START_LEVEL=1'b0, DATA_BITS=8.
- Sub-module fila_bit_timer: BIT_CYCLES down-counter with restart input and "tick" output. It is reused by STOP and GAP with a loadable count.
- Everything else lives in fila_drain_tx.

Test Plan:
1. Hold reset=0, then release with len_in=0 for 20 cycles -> tx_out=1, dequeue_out never 1, busy_out=0, sent_count_out=0.
2. Defaults; len_in=1, data_in=8'h11, enable_in=1:
   - dequeue_out high exactly 1 cycle;
   - tx_out sequence 0,1,0,0,0,1,0,0,0,1 (start, LSB-first 0x11, stop);
   - sent_count_out=1;
   - with len_in driven to 0 after the pop, stays in IDLE.
3. Bench model of fila preloaded with 11,22,...,99 (len 9) -> 9 pops, decoded bytes 11..99 in order, sent_count_out=9, minimum GAP_CYCLES idle between frames.
4. PARITY_EN=1, STOP_BITS=2, BIT_CYCLES=3, data_in=8'h07 -> parity bit 1; frame length 36 cycles; stop held high for 6 cycles.
5. enable_in=0 with len_in=5 -> no pops. Set enable_in=1, send one frame, drop enable_in mid-DATA -> the current frame completes, and no further pop follows.
6. Assert reset=0 during DATA of byte 8'hA5 -> tx_out=1 in the same cycle and all outputs return to reset values. After release with len_in=0, stays in IDLE.
